// File: rtl/pc_interrupt_sequencer_if.sv
// Handshake bundle between the instruction decoder/sequencer and the
// interrupt sequencer in front of the program counter.
//   master : decoder side, drives phase strobes, decoded RETI/EI/DI and raw requests
//   slave  : interrupt sequencer, drives PC select, return-register loads, acks,
//            global enable and current nesting level
interface pc_interrupt_sequencer_if;
    logic       FETCH;
    logic       DECODE;
    logic       PC_ENX;
    logic       INT0_REQ;
    logic       INT1_REQ;
    logic       RETI;
    logic       EI;
    logic       DI;
    logic [2:0] PC_NEXTX;
    logic       PC_LD_INT0X;
    logic       PC_LD_INT1X;
    logic       INT0_ACK;
    logic       INT1_ACK;
    logic       INTEN;
    logic [1:0] ISR_LEVEL;

    modport master (
        output FETCH, DECODE, PC_ENX, INT0_REQ, INT1_REQ, RETI, EI, DI,
        input  PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK, INTEN, ISR_LEVEL
    );

    modport slave (
        input  FETCH, DECODE, PC_ENX, INT0_REQ, INT1_REQ, RETI, EI, DI,
        output PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK, INTEN, ISR_LEVEL
    );
endinterface

// File: rtl/pc_interrupt_sequencer.sv
// Interrupt and return sequencer for the program counter.
// Synchronises INT0_REQ (high priority) and INT1_REQ (low priority), latches
// rising edges as pending, and at each FETCH & PC_ENX decision point selects
// the PC next address: sequential, vector INTV0 (0x0004) / INTV1 (0x0008), or
// return through the INT0/INT1 return register. One level of nesting: INT0
// may preempt an INT1 handler, never the reverse.
// Ports:
//   CLK     system clock, rising edge
//   RESETN  asynchronous active-low reset
//   bus     slave side of pc_interrupt_sequencer_if (strobes in; PC_NEXTX,
//           PC_LD_INTxX, INTx_ACK, INTEN, ISR_LEVEL out)
module pc_interrupt_sequencer (
    input  logic                      CLK,
    input  logic                      RESETN,
    pc_interrupt_sequencer_if.slave   bus
);
    localparam logic [2:0] PC_NEXTX_NEXT  = 3'd0;
    localparam logic [2:0] PC_NEXTX_INTV0 = 3'd1;
    localparam logic [2:0] PC_NEXTX_INTV1 = 3'd2;
    localparam logic [2:0] PC_NEXTX_INTR0 = 3'd3;
    localparam logic [2:0] PC_NEXTX_INTR1 = 3'd4;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        IN1       = 2'b01,
        IN0       = 2'b10,
        IN0_OVER1 = 2'b11
    } state_t;

    state_t     state, next_state;
    logic [1:0] sync0, sync1;
    logic       prev0, prev1;
    logic       pend0, pend1;
    logic       ret_pend;
    logic       inten;
    logic       edge0, edge1;
    logic       decision;
    logic [2:0] nextx;
    logic       take0, take1;

    assign edge0    = sync0[1] & ~prev0;
    assign edge1    = sync1[1] & ~prev1;
    assign decision = bus.FETCH & bus.PC_ENX;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= IDLE;
            sync0    <= '0;
            sync1    <= '0;
            prev0    <= 1'b0;
            prev1    <= 1'b0;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            ret_pend <= 1'b0;
            inten    <= 1'b0;
        end else begin
            state    <= next_state;
            sync0    <= {sync0[0], bus.INT0_REQ};
            sync1    <= {sync1[0], bus.INT1_REQ};
            prev0    <= sync0[1];
            prev1    <= sync1[1];
            // A new edge in the same cycle as the take keeps the request alive
            pend0    <= edge0 | (pend0 & ~take0);
            pend1    <= edge1 | (pend1 & ~take1);
            if (bus.DECODE && bus.RETI) begin
                ret_pend <= 1'b1;
            end else if (decision) begin
                ret_pend <= 1'b0;
            end
            if (bus.DECODE) begin
                if (bus.DI) begin
                    inten <= 1'b0;
                end else if (bus.EI) begin
                    inten <= 1'b1;
                end
            end
        end
    end

    // Return has strict precedence, so a return and a take never share a
    // decision point; the take falls to the next one.
    always_comb begin
        next_state = state;
        nextx      = PC_NEXTX_NEXT;
        take0      = 1'b0;
        take1      = 1'b0;
        if (decision) begin
            if (ret_pend) begin
                case (state)
                    IN0: begin
                        next_state = IDLE;
                        nextx      = PC_NEXTX_INTR0;
                    end
                    IN0_OVER1: begin
                        next_state = IN1;
                        nextx      = PC_NEXTX_INTR0;
                    end
                    IN1: begin
                        next_state = IDLE;
                        nextx      = PC_NEXTX_INTR1;
                    end
                    default: ;
                endcase
            end else if (inten && pend0 && (state == IDLE || state == IN1)) begin
                take0      = 1'b1;
                nextx      = PC_NEXTX_INTV0;
                next_state = (state == IN1) ? IN0_OVER1 : IN0;
            end else if (inten && pend1 && state == IDLE) begin
                take1      = 1'b1;
                nextx      = PC_NEXTX_INTV1;
                next_state = IN1;
            end
        end
    end

    assign bus.PC_NEXTX    = nextx;
    assign bus.PC_LD_INT0X = take0;
    assign bus.PC_LD_INT1X = take1;
    assign bus.INT0_ACK    = take0;
    assign bus.INT1_ACK    = take1;
    assign bus.INTEN       = inten;
    assign bus.ISR_LEVEL   = state;
endmodule

// File: tb/tb_pc_interrupt_sequencer.sv
// Directed, table-driven bench for pc_interrupt_sequencer. Each record is one
// clock cycle: inputs applied after the falling edge, outputs compared 1 ns
// later, before the next rising edge.
module tb_pc_interrupt_sequencer;
    localparam logic [2:0] S_NEXT  = 3'd0;
    localparam logic [2:0] S_INTV0 = 3'd1;
    localparam logic [2:0] S_INTV1 = 3'd2;
    localparam logic [2:0] S_INTR0 = 3'd3;
    localparam logic [2:0] S_INTR1 = 3'd4;

    // input bits: {DECODE, FETCH, PC_ENX, RETI, EI, DI, INT0_REQ, INT1_REQ}
    localparam logic [7:0] I0  = 8'h00;
    localparam logic [7:0] D   = 8'h80;
    localparam logic [7:0] F   = 8'h60;
    localparam logic [7:0] FO  = 8'h40;
    localparam logic [7:0] RT  = 8'h10;
    localparam logic [7:0] EN  = 8'h08;
    localparam logic [7:0] DS  = 8'h04;
    localparam logic [7:0] Q0  = 8'h02;
    localparam logic [7:0] Q1  = 8'h01;
    // strobes: {PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK}
    localparam logic [3:0] NS  = 4'b0000;
    localparam logic [3:0] TK0 = 4'b1010;
    localparam logic [3:0] TK1 = 4'b0101;

    typedef struct packed {
        logic [7:0] ins;
        logic [2:0] nx;
        logic [3:0] strb;
        logic       inten;
        logic [1:0] lvl;
    } vec_t;

    logic CLK;
    logic RESETN;
    int   checks;
    int   errors;
    vec_t tbl[$];

    pc_interrupt_sequencer_if bus();

    pc_interrupt_sequencer dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mk(input logic [7:0] ins, input logic [2:0] nx,
                                input logic [3:0] strb, input logic inten,
                                input logic [1:0] lvl);
        vec_t v;
        v.ins = ins; v.nx = nx; v.strb = strb; v.inten = inten; v.lvl = lvl;
        return v;
    endfunction

    task automatic check(input string nm, input logic [9:0] exp);
        logic [9:0] got;
        got = {bus.PC_NEXTX, bus.PC_LD_INT0X, bus.PC_LD_INT1X, bus.INT0_ACK,
               bus.INT1_ACK, bus.INTEN, bus.ISR_LEVEL};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {nx,ld0,ld1,ack0,ack1,inten,lvl}=%b expected %b", nm, got, exp);
        end
    endtask

    task automatic set_inputs(input logic [7:0] ins);
        {bus.DECODE, bus.FETCH, bus.PC_ENX, bus.RETI, bus.EI, bus.DI,
         bus.INT0_REQ, bus.INT1_REQ} = ins;
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge CLK);
        set_inputs(v.ins);
        #1;
        check(nm, {v.nx, v.strb, v.inten, v.lvl});
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // INT1 round trip
        tbl.push_back(mk(I0,      S_NEXT,  NS,  0, 2'd0)); // 0
        tbl.push_back(mk(D|EN,    S_NEXT,  NS,  0, 2'd0)); // 1 EI
        tbl.push_back(mk(Q1,      S_NEXT,  NS,  1, 2'd0)); // 2 INT1 rises
        tbl.push_back(mk(Q1,      S_NEXT,  NS,  1, 2'd0));
        tbl.push_back(mk(F|Q1,    S_NEXT,  NS,  1, 2'd0)); // 4 not pending yet
        tbl.push_back(mk(F|Q1,    S_INTV1, TK1, 1, 2'd0)); // 5 take INT1
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd1));
        tbl.push_back(mk(F,       S_NEXT,  NS,  1, 2'd1)); // 7 no second ack
        // nesting INT0 over INT1
        tbl.push_back(mk(Q0,      S_NEXT,  NS,  1, 2'd1)); // 8
        tbl.push_back(mk(Q0,      S_NEXT,  NS,  1, 2'd1));
        tbl.push_back(mk(Q0,      S_NEXT,  NS,  1, 2'd1));
        tbl.push_back(mk(F|Q0,    S_INTV0, TK0, 1, 2'd1)); // 11 preempt
        tbl.push_back(mk(D|RT,    S_NEXT,  NS,  1, 2'd3));
        tbl.push_back(mk(F,       S_INTR0, NS,  1, 2'd3)); // 13
        tbl.push_back(mk(D|RT,    S_NEXT,  NS,  1, 2'd1));
        tbl.push_back(mk(F,       S_INTR1, NS,  1, 2'd1)); // 15
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd0));
        // simultaneous requests
        tbl.push_back(mk(Q0|Q1,   S_NEXT,  NS,  1, 2'd0)); // 17
        tbl.push_back(mk(Q0|Q1,   S_NEXT,  NS,  1, 2'd0));
        tbl.push_back(mk(Q0|Q1,   S_NEXT,  NS,  1, 2'd0));
        tbl.push_back(mk(F|Q0|Q1, S_INTV0, TK0, 1, 2'd0)); // 20
        tbl.push_back(mk(F,       S_NEXT,  NS,  1, 2'd2)); // INT1 blocked in IN0
        tbl.push_back(mk(D|RT,    S_NEXT,  NS,  1, 2'd2));
        tbl.push_back(mk(F,       S_INTR0, NS,  1, 2'd2)); // 23
        tbl.push_back(mk(F,       S_INTV1, TK1, 1, 2'd0)); // 24
        tbl.push_back(mk(D|RT,    S_NEXT,  NS,  1, 2'd1));
        tbl.push_back(mk(F,       S_INTR1, NS,  1, 2'd1));
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd0));
        // masking
        tbl.push_back(mk(D|DS,    S_NEXT,  NS,  1, 2'd0)); // 28 DI
        tbl.push_back(mk(Q0,      S_NEXT,  NS,  0, 2'd0));
        tbl.push_back(mk(Q0,      S_NEXT,  NS,  0, 2'd0));
        tbl.push_back(mk(Q0,      S_NEXT,  NS,  0, 2'd0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(F,   S_NEXT,  NS,  0, 2'd0)); // 32..36 held
        tbl.push_back(mk(D|EN,    S_NEXT,  NS,  0, 2'd0)); // 37
        tbl.push_back(mk(F,       S_INTV0, TK0, 1, 2'd0)); // 38
        tbl.push_back(mk(D|RT,    S_NEXT,  NS,  1, 2'd2));
        tbl.push_back(mk(FO,      S_NEXT,  NS,  1, 2'd2)); // 40 stall
        tbl.push_back(mk(F,       S_INTR0, NS,  1, 2'd2));
        tbl.push_back(mk(D|EN|DS, S_NEXT,  NS,  1, 2'd0)); // 42 DI wins
        tbl.push_back(mk(I0,      S_NEXT,  NS,  0, 2'd0));
        // RETI in IDLE
        tbl.push_back(mk(D|RT,    S_NEXT,  NS,  0, 2'd0)); // 44
        tbl.push_back(mk(F,       S_NEXT,  NS,  0, 2'd0));
        tbl.push_back(mk(I0,      S_NEXT,  NS,  0, 2'd0));
        tbl.push_back(mk(D|EN,    S_NEXT,  NS,  0, 2'd0));
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd0)); // 48
        // two INT1 edges while pending
        tbl.push_back(mk(Q1,      S_NEXT,  NS,  1, 2'd0)); // 49
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd0));
        tbl.push_back(mk(Q1,      S_NEXT,  NS,  1, 2'd0));
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd0));
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd0));
        tbl.push_back(mk(F,       S_INTV1, TK1, 1, 2'd0)); // 54
        tbl.push_back(mk(F,       S_NEXT,  NS,  1, 2'd1)); // 55 only one ack
        // return vs take
        tbl.push_back(mk(D|RT|Q1, S_NEXT,  NS,  1, 2'd1)); // 56
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd1));
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd1));
        tbl.push_back(mk(F,       S_INTR1, NS,  1, 2'd1)); // 59 return first
        tbl.push_back(mk(F,       S_INTV1, TK1, 1, 2'd0)); // 60 then take
        tbl.push_back(mk(I0,      S_NEXT,  NS,  1, 2'd1));

        // reset state, with a decision point presented
        set_inputs(F);
        RESETN = 1'b0;
        #12;
        check("reset_state", {S_NEXT, NS, 1'b0, 2'd0});
        set_inputs(I0);
        @(negedge CLK);
        RESETN = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // reset mid-ISR: reach IN0_OVER1 with PEND1 and RET_PEND set
        apply(mk(Q0|Q1, S_NEXT,  NS,  1, 2'd1), "mid_a");
        apply(mk(Q0|Q1, S_NEXT,  NS,  1, 2'd1), "mid_b");
        apply(mk(Q0|Q1, S_NEXT,  NS,  1, 2'd1), "mid_c");
        apply(mk(F,     S_INTV0, TK0, 1, 2'd1), "mid_take0");
        apply(mk(D|RT,  S_NEXT,  NS,  1, 2'd3), "mid_over1");
        apply(mk(F,     S_INTR0, NS,  1, 2'd3), "mid_pre_reset");
        #2;
        RESETN = 1'b0;
        #1;
        check("async_reset", {S_NEXT, NS, 1'b0, 2'd0});
        set_inputs(I0);
        @(negedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        apply(mk(D|EN,  S_NEXT,  NS,  0, 2'd0), "post_reset_ei");
        apply(mk(F,     S_NEXT,  NS,  1, 2'd0), "pend_lost");
        apply(mk(I0,    S_NEXT,  NS,  1, 2'd0), "post_reset_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
